// File: rtl/regfile_wb_scheduler.sv
// regfile_wb_scheduler
//
// Write-back scheduler and read-after-write hazard scoreboard for a
// 2**N-entry register bank whose top entry is the PC (supplied externally,
// never written here). Two write-back requesters share the single bank write
// port with round-robin priority. A 2-bit pending counter per writable
// register lets the issue stage stall on outstanding producers.
//
// Ports:
//   clk, rst                  clock (rising edge), async active-high reset
//   res_valid/res_addr        issue stage reserves a destination register
//   res_ready                 reservation accepted this cycle (comb)
//   req0_valid/addr/data      write-back requester 0 (ALU path)
//   req1_valid/addr/data      write-back requester 1 (memory path)
//   req0_ready/req1_ready     grant (comb)
//   A1, A2                    issue-stage read addresses
//   stall                     read hazard on A1 or A2 (comb)
//   WE3, A3, WD3              registered bank write port
//   wb_err                    sticky: write-back to a register with no
//                             pending reservation
//
// Handshake: every valid/ready pair transfers on a rising edge where both
// are high. A requester holds valid, addr and data stable until it
// transfers; ready never depends on the requester's own addr/data.

module regfile_wb_scheduler #(
    parameter int N = 4,
    parameter int M = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         res_valid,
    input  logic [N-1:0] res_addr,
    output logic         res_ready,
    input  logic         req0_valid,
    input  logic [N-1:0] req0_addr,
    input  logic [M-1:0] req0_data,
    output logic         req0_ready,
    input  logic         req1_valid,
    input  logic [N-1:0] req1_addr,
    input  logic [M-1:0] req1_data,
    output logic         req1_ready,
    input  logic [N-1:0] A1,
    input  logic [N-1:0] A2,
    output logic         stall,
    output logic         WE3,
    output logic [N-1:0] A3,
    output logic [M-1:0] WD3,
    output logic         wb_err
);

    localparam int           NREG    = 2 ** N;
    localparam logic [N-1:0] PC_ADDR = N'(NREG - 1);

    // Pending counters exist only for the writable registers 0..NREG-2.
    logic [1:0] cnt_q [NREG-1];
    logic [1:0] cnt_d [NREG-1];
    // Full-width view with the PC slot tied to zero, so any address can
    // index it directly.
    logic [1:0] cnt_view [NREG];

    logic         rr_q, rr_d;      // 1 = requester 1 preferred on a tie
    logic         grant0, grant1;
    logic         wr_fire;         // a write-back transfers this cycle
    logic         wr_reg;          // ...and targets a writable register
    logic [N-1:0] wr_addr;
    logic [M-1:0] wr_data;
    logic         res_fire;
    logic         err_set;
    logic         hit_a1, hit_a2;

    always_comb begin
        for (int r = 0; r < NREG - 1; r++) begin
            cnt_view[r] = cnt_q[r];
        end
        cnt_view[NREG-1] = 2'd0;
    end

    // Reservation: refused only when the target counter is saturated.
    // The saturation test uses the pre-update count.
    assign res_ready = !((res_addr != PC_ADDR) && (cnt_view[res_addr] == 2'd3));
    assign res_fire  = res_valid && res_ready && (res_addr != PC_ADDR);

    // Round-robin arbitration: a lone requester always wins; on a tie the
    // pointer decides.
    assign grant0     = req0_valid && (!req1_valid || !rr_q);
    assign grant1     = req1_valid && (!req0_valid ||  rr_q);
    assign req0_ready = grant0;
    assign req1_ready = grant1;

    assign wr_fire = grant0 || grant1;
    assign wr_addr = grant0 ? req0_addr : req1_addr;
    assign wr_data = grant0 ? req0_data : req1_data;
    // Writes to the PC slot are consumed and dropped.
    assign wr_reg  = wr_fire && (wr_addr != PC_ADDR);

    // The pointer only moves when both requesters competed; it then points
    // at the loser so it wins next time.
    always_comb begin
        rr_d = rr_q;
        if (req0_valid && req1_valid) begin
            rr_d = grant0;
        end
    end

    // Counter next state. A same-cycle reserve and write-back on one
    // register cancel out. A write-back against a zero count leaves the
    // count at zero and raises the sticky error.
    always_comb begin
        err_set = 1'b0;
        for (int r = 0; r < NREG - 1; r++) begin
            logic inc, dec;
            inc      = res_fire && (res_addr == N'(r));
            dec      = wr_reg && (wr_addr == N'(r));
            cnt_d[r] = cnt_q[r];
            if (inc && !dec) begin
                cnt_d[r] = cnt_q[r] + 2'd1;
            end else if (dec && !inc && (cnt_q[r] != 2'd0)) begin
                cnt_d[r] = cnt_q[r] - 2'd1;
            end
            if (dec && (cnt_q[r] == 2'd0)) begin
                err_set = 1'b1;
            end
        end
    end

    // A register is busy while producers are pending or while its final
    // value sits in the write-port register, not yet in the bank.
    assign hit_a1 = (A1 != PC_ADDR) && ((cnt_view[A1] != 2'd0) || (WE3 && (A3 == A1)));
    assign hit_a2 = (A2 != PC_ADDR) && ((cnt_view[A2] != 2'd0) || (WE3 && (A3 == A2)));
    assign stall  = hit_a1 || hit_a2;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int r = 0; r < NREG - 1; r++) begin
                cnt_q[r] <= 2'd0;
            end
            rr_q   <= 1'b0;
            WE3    <= 1'b0;
            A3     <= '0;
            WD3    <= '0;
            wb_err <= 1'b0;
        end else begin
            for (int r = 0; r < NREG - 1; r++) begin
                cnt_q[r] <= cnt_d[r];
            end
            rr_q <= rr_d;
            WE3  <= wr_reg;
            // Address/data hold when nothing transfers.
            if (wr_fire) begin
                A3  <= wr_addr;
                WD3 <= wr_data;
            end
            if (err_set) begin
                wb_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_regfile_wb_scheduler.sv
module tb_regfile_wb_scheduler;

    logic        clk;
    logic        rst;
    logic        res_valid;
    logic [3:0]  res_addr;
    logic        res_ready;
    logic        req0_valid;
    logic [3:0]  req0_addr;
    logic [31:0] req0_data;
    logic        req0_ready;
    logic        req1_valid;
    logic [3:0]  req1_addr;
    logic [31:0] req1_data;
    logic        req1_ready;
    logic [3:0]  A1;
    logic [3:0]  A2;
    logic        stall;
    logic        WE3;
    logic [3:0]  A3;
    logic [31:0] WD3;
    logic        wb_err;

    int total = 0;
    int bad   = 0;

    regfile_wb_scheduler #(.N(4), .M(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .res_valid  (res_valid),
        .res_addr   (res_addr),
        .res_ready  (res_ready),
        .req0_valid (req0_valid),
        .req0_addr  (req0_addr),
        .req0_data  (req0_data),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_addr  (req1_addr),
        .req1_data  (req1_data),
        .req1_ready (req1_ready),
        .A1         (A1),
        .A2         (A2),
        .stall      (stall),
        .WE3        (WE3),
        .A3         (A3),
        .WD3        (WD3),
        .wb_err     (wb_err)
    );

    // clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        res_v;
        logic [3:0]  res_a;
        logic        r0v;
        logic [3:0]  r0a;
        logic [31:0] r0d;
        logic        r1v;
        logic [3:0]  r1a;
        logic [31:0] r1d;
        logic [3:0]  a1;
        logic [3:0]  a2;
        logic        e_rdy;
        logic        e_g0;
        logic        e_g1;
        logic        e_st;
        logic        e_we;
        logic [3:0]  e_a3;
        logic [31:0] e_wd;
        logic        e_err;
    } vec_t;

    vec_t vt[17];

    function automatic vec_t mk(
        input logic rv, input logic [3:0] ra,
        input logic v0, input logic [3:0] a0, input logic [31:0] d0,
        input logic v1, input logic [3:0] a1i, input logic [31:0] d1,
        input logic [3:0] x1, input logic [3:0] x2,
        input logic rdy, input logic g0, input logic g1, input logic st,
        input logic we, input logic [3:0] a3e, input logic [31:0] wde, input logic er);
        vec_t v;
        v.res_v = rv;  v.res_a = ra;
        v.r0v = v0;    v.r0a = a0;   v.r0d = d0;
        v.r1v = v1;    v.r1a = a1i;  v.r1d = d1;
        v.a1 = x1;     v.a2 = x2;
        v.e_rdy = rdy; v.e_g0 = g0;  v.e_g1 = g1; v.e_st = st;
        v.e_we = we;   v.e_a3 = a3e; v.e_wd = wde; v.e_err = er;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic drive_idle();
        res_valid  = 1'b0; res_addr  = 4'd0;
        req0_valid = 1'b0; req0_addr = 4'd0; req0_data = 32'd0;
        req1_valid = 1'b0; req1_addr = 4'd0; req1_data = 32'd0;
    endtask

    // One reservation cycle; expects acceptance.
    task automatic reserve(input logic [3:0] a, input string nm);
        @(negedge clk);
        drive_idle();
        res_valid = 1'b1; res_addr = a;
        #1 chk(nm, 32'(res_ready), 32'd1);
        @(posedge clk);
    endtask

    initial begin
        int n0, n1;
        logic exp_g0;

        // reset
        rst = 1'b1;
        drive_idle();
        A1 = 4'd0; A2 = 4'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_res_ready", 32'(res_ready), 32'd1);
        chk("rst_stall",     32'(stall),     32'd0);
        chk("rst_we3",       32'(WE3),       32'd0);
        chk("rst_a3",        32'(A3),        32'd0);
        chk("rst_wd3",       WD3,            32'd0);
        chk("rst_wb_err",    32'(wb_err),    32'd0);

        // Directed vectors: comb outputs checked before the edge,
        // registered outputs checked just after it.
        vt[0]  = mk(1,3,  0,0,0,            0,0,0,             3,0,   1,0,0,0, 0,0,0,0);
        vt[1]  = mk(1,3,  0,0,0,            0,0,0,             3,0,   1,0,0,1, 0,0,0,0);
        vt[2]  = mk(0,0,  1,3,32'hA5A5A5A5, 0,0,0,             3,0,   1,1,0,1, 1,3,32'hA5A5A5A5,0);
        vt[3]  = mk(0,0,  0,0,0,            0,0,0,             3,0,   1,0,0,1, 0,3,32'hA5A5A5A5,0);
        vt[4]  = mk(0,0,  1,3,32'h11,       0,0,0,             3,0,   1,1,0,1, 1,3,32'h11,0);
        vt[5]  = mk(0,0,  0,0,0,            0,0,0,             3,0,   1,0,0,1, 0,3,32'h11,0);
        vt[6]  = mk(0,0,  0,0,0,            0,0,0,             3,0,   1,0,0,0, 0,3,32'h11,0);
        vt[7]  = mk(1,5,  0,0,0,            0,0,0,             0,5,   1,0,0,0, 0,3,32'h11,0);
        vt[8]  = mk(1,5,  0,0,0,            0,0,0,             0,5,   1,0,0,1, 0,3,32'h11,0);
        vt[9]  = mk(1,5,  0,0,0,            0,0,0,             0,5,   1,0,0,1, 0,3,32'h11,0);
        vt[10] = mk(1,5,  0,0,0,            0,0,0,             0,5,   0,0,0,1, 0,3,32'h11,0);
        vt[11] = mk(1,5,  1,5,32'h55,       0,0,0,             0,5,   0,1,0,1, 1,5,32'h55,0);
        vt[12] = mk(0,15, 0,0,0,            1,15,32'hDEAD,     15,15, 1,0,1,0, 0,15,32'hDEAD,0);
        vt[13] = mk(1,15, 0,0,0,            0,0,0,             15,15, 1,0,0,0, 0,15,32'hDEAD,0);
        vt[14] = mk(0,0,  0,0,0,            1,7,32'h77,        7,0,   1,0,1,0, 1,7,32'h77,1);
        vt[15] = mk(0,0,  0,0,0,            0,0,0,             7,0,   1,0,0,1, 0,7,32'h77,1);
        vt[16] = mk(0,0,  0,0,0,            0,0,0,             7,0,   1,0,0,0, 0,7,32'h77,1);

        for (int i = 0; i < 17; i++) begin
            @(negedge clk);
            res_valid  = vt[i].res_v; res_addr  = vt[i].res_a;
            req0_valid = vt[i].r0v;   req0_addr = vt[i].r0a; req0_data = vt[i].r0d;
            req1_valid = vt[i].r1v;   req1_addr = vt[i].r1a; req1_data = vt[i].r1d;
            A1 = vt[i].a1; A2 = vt[i].a2;
            #1;
            chk($sformatf("v%0d_res_ready", i),  32'(res_ready),  32'(vt[i].e_rdy));
            chk($sformatf("v%0d_req0_ready", i), 32'(req0_ready), 32'(vt[i].e_g0));
            chk($sformatf("v%0d_req1_ready", i), 32'(req1_ready), 32'(vt[i].e_g1));
            chk($sformatf("v%0d_stall", i),      32'(stall),      32'(vt[i].e_st));
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_we3", i),    32'(WE3),    32'(vt[i].e_we));
            chk($sformatf("v%0d_a3", i),     32'(A3),     32'(vt[i].e_a3));
            chk($sformatf("v%0d_wd3", i),    WD3,         vt[i].e_wd);
            chk($sformatf("v%0d_wb_err", i), 32'(wb_err), 32'(vt[i].e_err));
        end

        // Round-robin: both requesters valid; req0 -> R1, req1 -> R2.
        for (int k = 0; k < 3; k++) reserve(4'd1, $sformatf("rr_res1_%0d", k));
        for (int k = 0; k < 3; k++) reserve(4'd2, $sformatf("rr_res2_%0d", k));
        n0 = 0; n1 = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            drive_idle();
            req0_valid = (n0 < 3); req0_addr = 4'd1; req0_data = 32'h1000 + 32'(n0);
            req1_valid = (n1 < 3); req1_addr = 4'd2; req1_data = 32'h2000 + 32'(n1);
            // Grants alternate 0,1,0,1,0; req1 then finishes alone.
            exp_g0 = (k % 2 == 0) && (k < 5);
            #1;
            chk($sformatf("rr%0d_req0_ready", k), 32'(req0_ready), 32'(exp_g0));
            chk($sformatf("rr%0d_req1_ready", k), 32'(req1_ready), 32'(!exp_g0));
            @(posedge clk);
            #1;
            chk($sformatf("rr%0d_we3", k), 32'(WE3), 32'd1);
            chk($sformatf("rr%0d_a3", k),  32'(A3),  exp_g0 ? 32'd1 : 32'd2);
            chk($sformatf("rr%0d_wd3", k), WD3, exp_g0 ? 32'h1000 + 32'(n0) : 32'h2000 + 32'(n1));
            if (exp_g0) n0++; else n1++;
        end
        // Last write (R2) still staged, then clears.
        @(negedge clk);
        drive_idle();
        A1 = 4'd1; A2 = 4'd2;
        #1 chk("rr_stall_staged", 32'(stall), 32'd1);
        @(negedge clk);
        #1 chk("rr_stall_clear", 32'(stall), 32'd0);

        // Asynchronous reset with a staged write and cnt[2] = 2.
        for (int k = 0; k < 3; k++) reserve(4'd2, $sformatf("ar_res2_%0d", k));
        @(negedge clk);
        drive_idle();
        req1_valid = 1'b1; req1_addr = 4'd2; req1_data = 32'hCAFE;
        A1 = 4'd2; A2 = 4'd15;
        #1 chk("ar_req1_ready", 32'(req1_ready), 32'd1);
        @(posedge clk);
        #1;
        drive_idle();
        res_addr = 4'd2;
        chk("ar_we3_pre",   32'(WE3),   32'd1);
        chk("ar_a3_pre",    32'(A3),    32'd2);
        chk("ar_stall_pre", 32'(stall), 32'd1);
        #1 rst = 1'b1;
        #1;
        chk("ar_we3",       32'(WE3),       32'd0);
        chk("ar_a3",        32'(A3),        32'd0);
        chk("ar_wd3",       WD3,            32'd0);
        chk("ar_stall",     32'(stall),     32'd0);
        chk("ar_res_ready", 32'(res_ready), 32'd1);
        chk("ar_wb_err",    32'(wb_err),    32'd0);
        @(negedge clk);
        rst = 1'b0;
        // Pointer was left preferring req1; reset returns it to req0.
        @(negedge clk);
        req0_valid = 1'b1; req0_addr = 4'd4; req0_data = 32'h44;
        req1_valid = 1'b1; req1_addr = 4'd6; req1_data = 32'h66;
        #1;
        chk("ar_rr_req0_ready", 32'(req0_ready), 32'd1);
        chk("ar_rr_req1_ready", 32'(req1_ready), 32'd0);
        @(posedge clk);
        #1;
        chk("ar_rr_a3",  32'(A3), 32'd4);
        chk("ar_rr_wd3", WD3,     32'h44);
        @(negedge clk);
        drive_idle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
